water_level_monitor: RTL and testbench

Multi-channel water-level monitor, the parametrised successor of the single-sensor level display. Each of NCH two-bit level sensors passes through a persistence filter. A sticky fault alarm is kept per channel. The seven-segment display scans through the channels automatically, showing one channel's filtered level letter plus its alarm on the decimal point. The block sits under `top`, fed from `SWI` and driving `SEG`/`LED`.

---
 rtl/water_level_monitor.sv | 102 ++++++++++
 tb/tb_water_level_monitor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/water_level_monitor.sv
// Multi-channel water-level monitor: per-channel persistence filter, sticky fault
// alarm, and a seven-segment display that scans the channels automatically.
module water_level_monitor #(
  parameter int NCH         = 2,
  parameter int NSTABLE     = 4,
  parameter int SCAN_CYCLES = 8,
  localparam int IW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk_2,
  input  logic               reset,
  input  logic [2*NCH-1:0]   sensor,
  input  logic               ack,
  input  logic               hold,
  output logic [2*NCH-1:0]   level,
  output logic [NCH-1:0]     alarm,
  output logic               any_alarm,
  output logic [IW-1:0]      ch_idx,
  output logic [7:0]         SEG
);

  localparam int CW = $clog2(NSTABLE + 1);
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_FULL  = CW'(NSTABLE);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [IW-1:0] CH_LAST   = IW'(NCH - 1);

  logic [NCH-1:0][1:0]    cand_q, cand_d;
  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][1:0]    level_q, level_d;
  logic [NCH-1:0]         alarm_q, alarm_d;
  logic [SW-1:0]          scan_q, scan_d;
  logic [IW-1:0]          ch_idx_q, ch_idx_d;

  function automatic logic [6:0] letter(input logic [1:0] code);
    case (code)
      2'b00:   letter = 7'h5F;
      2'b01:   letter = 7'h54;
      2'b10:   letter = 7'h7C;
      default: letter = 7'h5E;
    endcase
  endfunction

  // Filter and alarm next-state; alarm set/clear both look at the updated level
  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    alarm_d = alarm_q;
    for (int i = 0; i < NCH; i++) begin
      if (sensor[2*i +: 2] != cand_q[i]) begin
        cand_d[i] = sensor[2*i +: 2];
        cnt_d[i]  = CW'(1);
      end else if (cnt_q[i] != CNT_FULL) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
      if (cnt_d[i] == CNT_FULL)
        level_d[i] = cand_d[i];
      if (level_d[i] == 2'b11)
        alarm_d[i] = 1'b1;
      else if (ack)
        alarm_d[i] = 1'b0;
    end
  end

  always_comb begin
    scan_d   = scan_q;
    ch_idx_d = ch_idx_q;
    if (!hold) begin
      if (scan_q == SCAN_LAST) begin
        scan_d   = '0;
        ch_idx_d = (ch_idx_q == CH_LAST) ? '0 : ch_idx_q + IW'(1);
      end else begin
        scan_d = scan_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      cand_q   <= {NCH{2'b01}};
      cnt_q    <= {NCH{CNT_FULL}};
      level_q  <= {NCH{2'b01}};
      alarm_q  <= '0;
      scan_q   <= '0;
      ch_idx_q <= '0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      alarm_q  <= alarm_d;
      scan_q   <= scan_d;
      ch_idx_q <= ch_idx_d;
    end
  end

  assign level     = level_q;
  assign alarm     = alarm_q;
  assign any_alarm = |alarm_q;
  assign ch_idx    = ch_idx_q;
  assign SEG       = {alarm_q[ch_idx_q], letter(level_q[ch_idx_q])};

endmodule

// File: tb/tb_water_level_monitor.sv
// Bench for water_level_monitor: table vectors and hand sequences on a 2-channel
// instance, random stream on a 1-channel NSTABLE=1 instance, both via scoreboards.
module tb_water_level_monitor;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 2-channel instance
  logic       rst0, ack0, hold0, any0;
  logic [3:0] sensor0, level0;
  logic [1:0] alarm0;
  logic [0:0] ch0;
  logic [7:0] seg0;

  // 1-channel, NSTABLE=1 instance
  logic       rst1, ack1, hold1, any1;
  logic [1:0] sensor1, level1;
  logic [0:0] alarm1;
  logic [0:0] ch1;
  logic [7:0] seg1;

  water_level_monitor #(.NCH(2), .NSTABLE(4), .SCAN_CYCLES(8)) u0 (
    .clk_2(clk), .reset(rst0), .sensor(sensor0), .ack(ack0), .hold(hold0),
    .level(level0), .alarm(alarm0), .any_alarm(any0), .ch_idx(ch0), .SEG(seg0)
  );

  water_level_monitor #(.NCH(1), .NSTABLE(1), .SCAN_CYCLES(8)) u1 (
    .clk_2(clk), .reset(rst1), .sensor(sensor1), .ack(ack1), .hold(hold1),
    .level(level1), .alarm(alarm1), .any_alarm(any1), .ch_idx(ch1), .SEG(seg1)
  );

  typedef struct {
    logic [3:0] s;
    logic       a;
    logic [3:0] lvl;
    logic [1:0] alm;
  } vec_t;

  typedef struct {
    logic [3:0] lvl;
    logic [1:0] alm;
    logic       ch;
    logic [7:0] seg;
  } exp_t;

  typedef struct {
    logic [1:0] lvl;
    logic       alm;
    logic [7:0] seg;
  } exp1_t;

  vec_t  tbl[$];
  exp_t  sb[$];
  exp1_t sb1[$];
  int    total = 0;
  int    bad   = 0;
  int    scan_m = 0;
  logic  ch_m   = 1'b0;

  function automatic logic [6:0] pat(input logic [1:0] c);
    case (c)
      2'b00:   return 7'h5F;
      2'b01:   return 7'h54;
      2'b10:   return 7'h7C;
      default: return 7'h5E;
    endcase
  endfunction

  function automatic void add(input logic [3:0] s, input logic a, input logic [3:0] l,
                              input logic [1:0] al, input int n);
    for (int k = 0; k < n; k++) tbl.push_back('{s, a, l, al});
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  // One clock of the 2-channel instance: drive, predict, then compare after the edge
  task automatic step0(input logic [3:0] s, input logic a, input logic h,
                       input logic [3:0] l, input logic [1:0] al);
    exp_t e;
    sensor0 = s; ack0 = a; hold0 = h;
    if (!h) begin
      if (scan_m == 7) begin scan_m = 0; ch_m = ~ch_m; end
      else scan_m++;
    end
    e.lvl = l; e.alm = al; e.ch = ch_m;
    e.seg = {al[ch_m], pat(l[2*ch_m +: 2])};
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      chk("level", {4'b0, level0}, {4'b0, e.lvl});
      chk("alarm", {6'b0, alarm0}, {6'b0, e.alm});
      chk("any_alarm", {7'b0, any0}, {7'b0, |e.alm});
      chk("ch_idx", {7'b0, ch0}, {7'b0, e.ch});
      chk("seg", seg0, e.seg);
    end
  endtask

  task automatic reset_vals0(input string nm);
    chk({nm, "_level"}, {4'b0, level0}, 8'h05);
    chk({nm, "_alarm"}, {6'b0, alarm0}, 8'h00);
    chk({nm, "_any"}, {7'b0, any0}, 8'h00);
    chk({nm, "_ch"}, {7'b0, ch0}, 8'h00);
    chk({nm, "_seg"}, seg0, 8'h54);
  endtask

  initial begin
    exp1_t e1;
    logic  alm_m;
    logic [1:0] s1;
    logic  a1;

    rst0 = 1'b1; sensor0 = 4'b0101; ack0 = 1'b0; hold0 = 1'b0;
    rst1 = 1'b1; sensor1 = 2'b01;   ack1 = 1'b0; hold1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_vals0("rst");
    rst0 = 1'b0;

    // reset hold, ch0 -> alto, ch1 short fault glitch, padding, ch1 long fault with acks
    add(4'b0101, 0, 4'b0101, 2'b00, 3);
    add(4'b0100, 0, 4'b0101, 2'b00, 3);
    add(4'b0100, 0, 4'b0100, 2'b00, 3);
    add(4'b1100, 0, 4'b0100, 2'b00, 3);
    add(4'b0100, 0, 4'b0100, 2'b00, 8);
    add(4'b1100, 0, 4'b0100, 2'b00, 3);
    add(4'b1100, 0, 4'b1100, 2'b10, 2);
    add(4'b1100, 1, 4'b1100, 2'b10, 1);
    add(4'b0100, 0, 4'b1100, 2'b10, 3);
    add(4'b0100, 0, 4'b0100, 2'b10, 1);
    add(4'b0100, 1, 4'b0100, 2'b00, 2);
    add(4'b0100, 0, 4'b0100, 2'b00, 1);
    for (int i = 0; i < tbl.size(); i++)
      step0(tbl[i].s, tbl[i].a, 1'b0, tbl[i].lvl, tbl[i].alm);

    // scan free-run, freeze, resume
    for (int i = 0; i < 32; i++) step0(4'b0100, 0, 0, 4'b0100, 2'b00);
    for (int i = 0; i < 5; i++)  step0(4'b0100, 0, 0, 4'b0100, 2'b00);
    for (int i = 0; i < 20; i++) step0(4'b0100, 0, 1, 4'b0100, 2'b00);
    for (int i = 0; i < 16; i++) step0(4'b0100, 0, 0, 4'b0100, 2'b00);

    // reset mid-count discards progress
    step0(4'b0000, 0, 0, 4'b0100, 2'b00);
    step0(4'b0000, 0, 0, 4'b0100, 2'b00);
    #2 rst0 = 1'b1;
    #1 reset_vals0("rst_mid");
    @(posedge clk); #1;
    rst0 = 1'b0; scan_m = 0; ch_m = 1'b0;
    for (int i = 0; i < 3; i++) step0(4'b0000, 0, 0, 4'b0101, 2'b00);
    step0(4'b0000, 0, 0, 4'b0000, 2'b00);

    // change on the completing edge restarts the count
    for (int i = 0; i < 3; i++) step0(4'b0010, 0, 0, 4'b0000, 2'b00);
    for (int i = 0; i < 3; i++) step0(4'b0011, 0, 0, 4'b0000, 2'b00);
    step0(4'b0011, 0, 0, 4'b0011, 2'b01);
    step0(4'b0011, 1, 0, 4'b0011, 2'b01);
    for (int i = 0; i < 3; i++) step0(4'b0000, 0, 0, 4'b0011, 2'b01);
    step0(4'b0000, 0, 0, 4'b0000, 2'b01);
    step0(4'b0000, 1, 0, 4'b0000, 2'b00);

    // single channel, NSTABLE=1: level is sensor delayed one clock
    rst1 = 1'b0;
    alm_m = 1'b0;
    for (int i = 0; i < 60; i++) begin
      s1 = 2'($urandom_range(0, 3));
      a1 = ($urandom_range(0, 3) == 0);
      sensor1 = s1; ack1 = a1; hold1 = (i >= 40);
      if (s1 == 2'b11) alm_m = 1'b1;
      else if (a1) alm_m = 1'b0;
      sb1.push_back('{s1, alm_m, {alm_m, pat(s1)}});
      @(posedge clk); #1;
      if (sb1.size() == 0) begin
        chk("sb1_empty", 8'd1, 8'd0);
      end else begin
        e1 = sb1.pop_front();
        chk("n1_level", {6'b0, level1}, {6'b0, e1.lvl});
        chk("n1_alarm", {7'b0, alarm1}, {7'b0, e1.alm});
        chk("n1_any", {7'b0, any1}, {7'b0, e1.alm});
        chk("n1_ch", {7'b0, ch1}, 8'h00);
        chk("n1_seg", seg1, e1.seg);
      end
    end
    sensor1 = 2'b11; ack1 = 1'b0;
    @(posedge clk); #1;
    chk("n1_fault_alarm", {7'b0, alarm1}, 8'h01);
    chk("n1_fault_seg", seg1, 8'hDE);
    #2 rst1 = 1'b1;
    #1;
    chk("n1_rst_level", {6'b0, level1}, 8'h01);
    chk("n1_rst_alarm", {7'b0, alarm1}, 8'h00);
    chk("n1_rst_any", {7'b0, any1}, 8'h00);
    chk("n1_rst_seg", seg1, 8'h54);
    @(posedge clk); #1;
    rst1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
